// File: rtl/traffic_light_sched.sv
// traffic_light_sched: prescaled phase scheduler for a two-way intersection with pedestrian WALK insertion
// Ports: clk/reset (sync, active-high), ena freezes prescaler and timer,
//   tick_div prescaler period, *_dur phase lengths in ticks, ped_req request in;
//   ped_ack pending request, main/side_lights {r,y,g}, walk lamp, phase = state, tick strobe out.
module traffic_light_sched #(
  parameter int DUR_W      = 7,
  parameter int ALLRED_DUR = 1,
  parameter int WALK_DUR   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic [7:0]       tick_div,
  input  logic [DUR_W-1:0] main_green_dur,
  input  logic [DUR_W-1:0] side_green_dur,
  input  logic [DUR_W-1:0] yellow_dur,
  input  logic             ped_req,
  output logic             ped_ack,
  output logic [2:0]       main_lights,
  output logic [2:0]       side_lights,
  output logic             walk,
  output logic [2:0]       phase,
  output logic             tick
);
  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALLRED_A    = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALLRED_B    = 3'd5,
    WALK        = 3'd6
  } state_t;

  localparam logic [DUR_W-1:0] ALLRED_LD = (ALLRED_DUR == 0) ? DUR_W'(1) : DUR_W'(ALLRED_DUR);
  localparam logic [DUR_W-1:0] WALK_LD   = (WALK_DUR == 0) ? DUR_W'(1) : DUR_W'(WALK_DUR);

  logic [7:0]       r_cnt;
  logic [7:0]       w_p;
  state_t           r_state;
  state_t           w_next;
  logic [DUR_W-1:0] r_timer;
  logic [DUR_W-1:0] w_dur;
  logic             w_adv;
  logic             w_illegal;

  function automatic logic [DUR_W-1:0] ld(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

  // >= rather than == so shrinking tick_div mid-count fires at once instead of wrapping
  always_comb begin
    w_p       = (tick_div == 8'd0) ? 8'd1 : tick_div;
    tick      = ena && (r_cnt >= w_p - 8'd1);
    w_adv     = tick && (r_timer == DUR_W'(1));
    w_illegal = (r_state == state_t'(3'd7));
  end

  always_comb begin
    w_next = r_state;
    w_dur  = r_timer;
    case (r_state)
      MAIN_GREEN:  begin w_next = MAIN_YELLOW; w_dur = ld(yellow_dur);     end
      MAIN_YELLOW: begin w_next = ALLRED_A;    w_dur = ALLRED_LD;          end
      ALLRED_A:    begin w_next = SIDE_GREEN;  w_dur = ld(side_green_dur); end
      SIDE_GREEN:  begin w_next = SIDE_YELLOW; w_dur = ld(yellow_dur);     end
      SIDE_YELLOW: begin w_next = ALLRED_B;    w_dur = ALLRED_LD;          end
      ALLRED_B:    begin
        w_next = ped_ack ? WALK : MAIN_GREEN;
        w_dur  = ped_ack ? WALK_LD : ld(main_green_dur);
      end
      WALK:        begin w_next = MAIN_GREEN;  w_dur = ld(main_green_dur); end
      default:     begin w_next = ALLRED_B;    w_dur = ALLRED_LD;          end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= 8'd0;
      r_state <= ALLRED_B;
      r_timer <= ALLRED_LD;
    end else begin
      if (ena) r_cnt <= tick ? 8'd0 : r_cnt + 8'd1;
      if (w_illegal || w_adv) begin
        r_state <= w_next;
        r_timer <= w_dur;
      end else if (tick) begin
        r_timer <= r_timer - DUR_W'(1);
      end
    end
  end

  // clearing on WALK entry takes priority over a simultaneous request
  always_ff @(posedge clk) begin
    if (reset) begin
      ped_ack     <= 1'b0;
      main_lights <= 3'b100;
      side_lights <= 3'b100;
      walk        <= 1'b0;
    end else begin
      ped_ack     <= (w_adv && r_state == ALLRED_B && ped_ack) ? 1'b0 :
                     (ped_req && r_state != WALK) ? 1'b1 : ped_ack;
      main_lights <= (r_state == MAIN_GREEN) ? 3'b001 : (r_state == MAIN_YELLOW) ? 3'b010 : 3'b100;
      side_lights <= (r_state == SIDE_GREEN) ? 3'b001 : (r_state == SIDE_YELLOW) ? 3'b010 : 3'b100;
      walk        <= (r_state == WALK);
    end
  end

  assign phase = r_state;
endmodule
